// File: rtl/dmem_bus_demux2_if.sv
// Bus bundle between the core's data-memory port, the demux and its two targets.
// slave:  the demux's view (accepts core requests, drives both target ports).
// master: the environment's view (core LSU plus the two targets).
interface dmem_bus_demux2_if;
    // Core request / response
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Target request side (fields shared by both targets)
    logic        t0_valid;
    logic        t1_valid;
    logic        t0_ready;
    logic        t1_ready;
    logic        t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_wstrb;

    // Target read-data return
    logic        t0_rvalid;
    logic        t1_rvalid;
    logic [31:0] t0_rdata;
    logic [31:0] t1_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output t0_valid, t1_valid, t_we, t_addr, t_wdata, t_wstrb,
        input  t0_ready, t1_ready,
        input  t0_rvalid, t1_rvalid, t0_rdata, t1_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  t0_valid, t1_valid, t_we, t_addr, t_wdata, t_wstrb,
        output t0_ready, t1_ready,
        output t0_rvalid, t1_rvalid, t0_rdata, t1_rdata
    );
endinterface

// File: rtl/dmem_bus_demux2.sv
// Data-memory port demux: routes one core request at a time to the data RAM
// (target 0) or the MMIO window (target 1) by address decode, and owns the
// transaction until a one-cycle response pulse. A hung target is converted
// into an error response after TIMEOUT cycles in ISSUE or WAIT.
module dmem_bus_demux2 #(
    parameter logic [31:0] T1_BASE = 32'h1000_0000,
    parameter logic [31:0] T1_MASK = 32'hF000_0000,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_bus_demux2_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RSP   = 2'd3
    } state_t;

    state_t        state;
    logic          sel;
    logic [CW-1:0] cnt;

    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;

    logic          t0_valid_q;
    logic          t1_valid_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;

    logic          hit;
    logic          misaligned;
    logic          sel_ready;
    logic          sel_rvalid;
    logic [31:0]   sel_rdata;
    logic          timed_out;

    assign hit        = ((bus.req_addr & T1_MASK) == T1_BASE);
    assign misaligned = (bus.req_addr[1:0] != 2'b00);
    assign timed_out  = (cnt == CW'(TIMEOUT - 1));

    // Handshake inputs from the selected target only; the other target is ignored.
    always_comb begin
        sel_ready  = bus.t0_ready;
        sel_rvalid = bus.t0_rvalid;
        sel_rdata  = bus.t0_rdata;
        if (sel) begin
            sel_ready  = bus.t1_ready;
            sel_rvalid = bus.t1_rvalid;
            sel_rdata  = bus.t1_rdata;
        end
    end

    // Transaction FSM with registered target and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= 1'b0;
            cnt         <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            t0_valid_q  <= 1'b0;
            t1_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            // rsp_valid is only raised on the transition into RSP, so it lasts one cycle
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        wstrb_q <= bus.req_wstrb;
                        sel     <= hit;
                        if (misaligned) begin
                            state       <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state      <= ISSUE;
                            cnt        <= '0;
                            t0_valid_q <= ~hit;
                            t1_valid_q <= hit;
                        end
                    end
                end
                ISSUE: begin
                    if (sel_ready) begin
                        t0_valid_q <= 1'b0;
                        t1_valid_q <= 1'b0;
                        if (we_q) begin
                            state       <= RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= '0;
                        end
                    end else if (timed_out) begin
                        t0_valid_q  <= 1'b0;
                        t1_valid_q  <= 1'b0;
                        state       <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (sel_rvalid) begin
                        state       <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= sel_rdata;
                    end else if (timed_out) begin
                        state       <= RSP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.t0_valid  = t0_valid_q;
    assign bus.t1_valid  = t1_valid_q;
    assign bus.t_we      = we_q;
    assign bus.t_addr    = addr_q;
    assign bus.t_wdata   = wdata_q;
    assign bus.t_wstrb   = wstrb_q;

endmodule

// File: tb/tb_dmem_bus_demux2.sv
// Directed testbench for dmem_bus_demux2. Cycle numbering: the edge that
// accepts a request is edge 0; "cycle c" is the period after edge c-1.
module tb_dmem_bus_demux2;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    dmem_bus_demux2_if bus ();

    dmem_bus_demux2 #(
        .T1_BASE (32'h1000_0000),
        .T1_MASK (32'hF000_0000),
        .TIMEOUT (16),
        .CW      (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.t0_ready  = 1'b0;
        bus.t1_ready  = 1'b0;
        bus.t0_rvalid = 1'b0;
        bus.t1_rvalid = 1'b0;
        bus.t0_rdata  = '0;
        bus.t1_rdata  = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1000_0000;
        tick();
        tick();
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.t0_valid, bus.t1_valid} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 10000", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.t0_valid, bus.t1_valid});
        end
        n_checks++;
        if ({bus.rsp_rdata, bus.t_addr, bus.t_wdata, bus.t_wstrb, bus.t_we} !== 101'd0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h wstrb=%h we=%b want all zero",
                     bus.rsp_rdata, bus.t_addr, bus.t_wdata, bus.t_wstrb, bus.t_we);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_load_t0;
        int          rsp_cyc = -1;
        int          rsp_cnt = 0;
        int          t1_seen = 0;
        logic [31:0] rd = '0;
        logic        er = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0000_0040;
        bus.req_wdata = 32'hDEAD_0000;
        bus.req_wstrb = 4'hF;
        bus.t0_ready  = 1'b1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_t0_req_ready: got %b want 1", bus.req_ready);
        end
        tick();
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) begin
                n_checks++;
                if ({bus.t0_valid, bus.t_we, bus.t_addr} !== {1'b1, 1'b0, 32'h0000_0040}) begin
                    n_fail++;
                    $display("FAIL load_t0_issue: got valid=%b we=%b addr=%h want 1 0 00000040", bus.t0_valid, bus.t_we, bus.t_addr);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (bus.t0_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_t0_wait_valid: got %b want 0", bus.t0_valid);
                end
            end
            if (bus.t1_valid) t1_seen++;
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = c;
                    rd      = bus.rsp_rdata;
                    er      = bus.rsp_err;
                end
            end
            bus.req_valid = 1'b0;
            bus.t0_rvalid = (c == 2);
            bus.t0_rdata  = (c == 2) ? 32'h1234_5678 : 32'h0BAD_0BAD;
            tick();
        end
        n_checks++;
        if (rsp_cyc !== 3 || rsp_cnt !== 1) begin
            n_fail++;
            $display("FAIL load_t0_latency: got cycle %0d count %0d want cycle 3 count 1", rsp_cyc, rsp_cnt);
        end
        n_checks++;
        if ({rd, er} !== {32'h1234_5678, 1'b0}) begin
            n_fail++;
            $display("FAIL load_t0_data: got rdata=%h err=%b want 12345678 0", rd, er);
        end
        n_checks++;
        if (t1_seen !== 0) begin
            n_fail++;
            $display("FAIL load_t0_no_t1: got %0d t1_valid cycles want 0", t1_seen);
        end
        n_checks++;
        if (bus.rsp_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL load_t0_rdata_hold: got %h want 12345678", bus.rsp_rdata);
        end
        idle_inputs();
    endtask

    task automatic test_store_t1;
        int          rsp_cyc = -1;
        int          rsp_cnt = 0;
        int          stable  = 0;
        int          t1_cnt  = 0;
        logic [31:0] rd = '1;
        logic        er = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h1000_0004;
        bus.req_wdata = 32'hA5A5_A5A5;
        bus.req_wstrb = 4'b0011;
        bus.t0_ready  = 1'b1;
        bus.t1_ready  = 1'b0;
        tick();
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4 && {bus.t1_valid, bus.t0_valid, bus.t_we, bus.t_addr, bus.t_wdata, bus.t_wstrb}
                          === {1'b1, 1'b0, 1'b1, 32'h1000_0004, 32'hA5A5_A5A5, 4'b0011})
                stable++;
            if (bus.t1_valid) t1_cnt++;
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = c;
                    rd      = bus.rsp_rdata;
                    er      = bus.rsp_err;
                end
            end
            // Core moves on: request fields change, but the latched copy must not
            bus.req_valid = 1'b0;
            bus.req_we    = 1'b0;
            bus.req_addr  = 32'hFFFF_FFFC;
            bus.req_wdata = 32'h0;
            bus.req_wstrb = 4'h0;
            bus.t1_ready  = (c == 4);
            tick();
        end
        n_checks++;
        if (stable !== 4 || t1_cnt !== 4) begin
            n_fail++;
            $display("FAIL store_t1_issue: got stable=%0d t1_valid=%0d want 4 4", stable, t1_cnt);
        end
        n_checks++;
        if (rsp_cyc !== 5 || rsp_cnt !== 1) begin
            n_fail++;
            $display("FAIL store_t1_latency: got cycle %0d count %0d want cycle 5 count 1", rsp_cyc, rsp_cnt);
        end
        n_checks++;
        if ({rd, er} !== {32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL store_t1_rsp: got rdata=%h err=%b want 00000000 0", rd, er);
        end
        idle_inputs();
    endtask

    task automatic test_misaligned;
        int          rsp_cyc = -1;
        int          tv_seen = 0;
        logic [31:0] rd = '1;
        logic        er = 1'b0;
        logic        rdy2 = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0042;
        bus.t0_ready  = 1'b1;
        bus.t1_ready  = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            if (bus.t0_valid || bus.t1_valid) tv_seen++;
            if (c == 2) rdy2 = bus.req_ready;
            if (bus.rsp_valid && rsp_cyc < 0) begin
                rsp_cyc = c;
                rd      = bus.rsp_rdata;
                er      = bus.rsp_err;
            end
            bus.req_valid = 1'b0;
            tick();
        end
        n_checks++;
        if (rsp_cyc !== 1) begin
            n_fail++;
            $display("FAIL misaligned_latency: got cycle %0d want 1", rsp_cyc);
        end
        n_checks++;
        if ({rd, er, tv_seen[3:0]} !== {32'h0, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL misaligned_rsp: got rdata=%h err=%b target_valid=%0d want 00000000 1 0", rd, er, tv_seen);
        end
        n_checks++;
        if (rdy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_ready_after: got %b want 1", rdy2);
        end
        idle_inputs();
    endtask

    task automatic test_cross_target;
        int          rsp_cyc = -1;
        int          rsp_cnt = 0;
        int          t0_seen = 0;
        logic [31:0] rd = '0;
        logic        er = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h1000_0010;
        bus.t0_ready  = 1'b1;
        bus.t1_ready  = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            if (bus.t0_valid) t0_seen++;
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = c;
                    rd      = bus.rsp_rdata;
                    er      = bus.rsp_err;
                end
            end
            bus.req_valid = 1'b0;
            bus.t0_rvalid = c[0];
            bus.t0_rdata  = 32'hFFFF_FFFF;
            // rvalid in the accept cycle and after the response must be ignored
            bus.t1_rvalid = (c == 1) || (c == 4) || (c == 6);
            bus.t1_rdata  = (c == 1) ? 32'hDEAD_BEEF : (c == 4) ? 32'h0000_00C3 : 32'h5555_5555;
            tick();
        end
        n_checks++;
        if (rsp_cyc !== 5 || rsp_cnt !== 1) begin
            n_fail++;
            $display("FAIL cross_latency: got cycle %0d count %0d want cycle 5 count 1", rsp_cyc, rsp_cnt);
        end
        n_checks++;
        if ({rd, er} !== {32'h0000_00C3, 1'b0}) begin
            n_fail++;
            $display("FAIL cross_data: got rdata=%h err=%b want 000000c3 0", rd, er);
        end
        n_checks++;
        if (t0_seen !== 0) begin
            n_fail++;
            $display("FAIL cross_no_t0: got %0d t0_valid cycles want 0", t0_seen);
        end
        idle_inputs();
    endtask

    task automatic test_timeout;
        int          rsp_cyc = -1;
        int          rsp_cnt = 0;
        int          bad_v   = 0;
        logic [31:0] rd = '1;
        logic        er = 1'b0;
        logic        rdy18 = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0100;
        bus.t0_ready  = 1'b0;
        tick();
        for (int c = 1; c <= 24; c++) begin
            if (bus.t0_valid !== (c <= 16)) bad_v++;
            if (c == 18) rdy18 = bus.req_ready;
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = c;
                    rd      = bus.rsp_rdata;
                    er      = bus.rsp_err;
                end
            end
            bus.req_valid = 1'b0;
            bus.t0_rvalid = (c == 20);
            bus.t0_rdata  = 32'h7777_7777;
            tick();
        end
        n_checks++;
        if (bad_v !== 0) begin
            n_fail++;
            $display("FAIL timeout_valid_window: got %0d cycles wrong want 0 (high exactly 1..16)", bad_v);
        end
        n_checks++;
        if (rsp_cyc !== 17 || rsp_cnt !== 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got cycle %0d count %0d want cycle 17 count 1", rsp_cyc, rsp_cnt);
        end
        n_checks++;
        if ({rd, er, rdy18} !== {32'h0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL timeout_rsp: got rdata=%h err=%b ready18=%b want 00000000 1 1", rd, er, rdy18);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait;
        int          rsp_cnt = 0;
        int          rsp_cyc = -1;
        logic [31:0] rd = '1;
        logic        er = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0080;
        bus.t0_ready  = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            if (bus.rsp_valid) rsp_cnt++;
            bus.req_valid = 1'b0;
            reset         = (c == 3);
            tick();
        end
        reset = 1'b0;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.t0_valid, bus.t_addr} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_wait_state: got ready=%b rsp=%b t0v=%b addr=%h want 1 0 0 00000000",
                     bus.req_ready, bus.rsp_valid, bus.t0_valid, bus.t_addr);
        end
        for (int c = 4; c <= 7; c++) begin
            if (bus.rsp_valid) rsp_cnt++;
            bus.t0_rvalid = (c <= 5);
            bus.t0_rdata  = 32'h9999_9999;
            tick();
        end
        n_checks++;
        if (rsp_cnt !== 0) begin
            n_fail++;
            $display("FAIL rst_wait_no_rsp: got %0d responses want 0", rsp_cnt);
        end
        bus.t0_rvalid = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0200;
        bus.req_wdata = 32'h1111_2222;
        bus.req_wstrb = 4'hF;
        bus.t0_ready  = 1'b1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            if (bus.rsp_valid && rsp_cyc < 0) begin
                rsp_cyc = c;
                rd      = bus.rsp_rdata;
                er      = bus.rsp_err;
            end
            bus.req_valid = 1'b0;
            tick();
        end
        n_checks++;
        if (rsp_cyc !== 2 || {rd, er} !== {32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_wait_fresh_store: got cycle %0d rdata=%h err=%b want 2 00000000 0", rsp_cyc, rd, er);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        int          rsp_a = -1;
        int          rsp_b = -1;
        logic        rdy3 = 1'b0;
        logic [31:0] addr4 = '0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0000_0300;
        bus.req_wdata = 32'h0000_0001;
        bus.req_wstrb = 4'hF;
        bus.t0_ready  = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            if (c == 3) rdy3 = bus.req_ready;
            if (c == 4) addr4 = bus.t_addr;
            if (bus.rsp_valid) begin
                if (rsp_a < 0) rsp_a = c;
                else if (rsp_b < 0) rsp_b = c;
            end
            // Request stays asserted through RSP; its address changes before the second accept
            if (c == 3) bus.req_addr = 32'h0000_0304;
            if (c == 4) bus.req_valid = 1'b0;
            tick();
        end
        n_checks++;
        if (rsp_a !== 2 || rsp_b !== 5) begin
            n_fail++;
            $display("FAIL b2b_latency: got cycles %0d,%0d want 2,5", rsp_a, rsp_b);
        end
        n_checks++;
        if ({rdy3, addr4} !== {1'b1, 32'h0000_0304}) begin
            n_fail++;
            $display("FAIL b2b_second_accept: got ready3=%b addr=%h want 1 00000304", rdy3, addr4);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load_t0();
        test_store_t1();
        test_misaligned();
        test_cross_target();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
